regfile_sb: RTL and testbench

//  Parametrised register file: NUM_REGS x DATA_W storage, one write port, two combinational read ports.

---
 rtl/regfile_sb_pkg.sv | 25 ++
 rtl/regfile_sb_if.sv | 53 +++++
 rtl/regfile_sb_regn_p.sv | 28 ++
 rtl/regfile_sb.sv | 148 ++++++++++++++
 tb/tb_regfile_sb.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
//   Shared constants and helpers for the register file / scoreboard slice.
//   DATA_W_DEF, NUM_REGS_DEF : default register width and register count.
//   clog2_min1               : index width for a register count, never below 1.
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;

    // Smallest w >= 1 such that 2**w >= n. Written as a bounded loop so it
    // elaborates as a constant function on every tool.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << k) < n) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
//   Bundles the writeback, read, issue and flush signals of the register file.
//   master : issue/decode + writeback side (drives indices, data, controls)
//   slave  : the register file (drives read data, busy flags, busy_vec)
//
//   we        write enable            waddr/wdata  write index / data
//   ra_addr   read port A index       ra_data/ra_busy  port A data / pending flag
//   rb_addr   read port B index       rb_data/rb_busy  port B data / pending flag
//   iss_valid issue strobe            iss_rd       destination to mark busy
//   flush     clear the scoreboard    busy_vec     raw scoreboard state
// -----------------------------------------------------------------------------
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
);
    localparam int ADDR_W = clog2_min1(NUM_REGS);

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;

    logic [ADDR_W-1:0]   ra_addr;
    logic [DATA_W-1:0]   ra_data;
    logic                ra_busy;

    logic [ADDR_W-1:0]   rb_addr;
    logic [DATA_W-1:0]   rb_data;
    logic                rb_busy;

    logic                iss_valid;
    logic [ADDR_W-1:0]   iss_rd;
    logic                flush;

    logic [NUM_REGS-1:0] busy_vec;

    modport master (
        output we, waddr, wdata,
        output ra_addr, rb_addr,
        output iss_valid, iss_rd, flush,
        input  ra_data, ra_busy, rb_data, rb_busy, busy_vec
    );

    modport slave (
        input  we, waddr, wdata,
        input  ra_addr, rb_addr,
        input  iss_valid, iss_rd, flush,
        output ra_data, ra_busy, rb_data, rb_busy, busy_vec
    );

endinterface

// File: rtl/regfile_sb_regn_p.sv
// -----------------------------------------------------------------------------
// regn_p
//   Enable register of width W with asynchronous active-low reset to 0.
//   clk    : rising-edge clock
//   resetn : asynchronous, active-low reset
//   en     : load enable
//   d      : next value, loaded when en=1
//   q      : registered value
// -----------------------------------------------------------------------------
module regn_p #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   NUM_REGS x DATA_W register file with one write port and two combinational
//   read ports, optional hardwired-zero register 0, optional write-to-read
//   bypass, and a per-register busy scoreboard that tracks destinations issued
//   but not yet written back.
//
//   clk    : rising-edge clock
//   resetn : asynchronous, active-low reset (clears registers and scoreboard)
//   bus    : regfile_sb_if.slave -- write port, read ports A/B, issue, flush,
//            busy_vec
//
//   Parameters: DATA_W, NUM_REGS (2..256, any value), ZERO_REG, BYPASS.
//   The index width is derived from NUM_REGS and is not a parameter.
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    regfile_sb_if.slave  bus
);

    localparam int                  ADDR_W    = clog2_min1(NUM_REGS);
    localparam logic [ADDR_W:0]     REG_COUNT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] ONE_HOT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};

    // An index is usable when it names a real register and is not the
    // hardwired zero register. Out-of-range indices are possible whenever
    // NUM_REGS is not a power of two.
    function automatic logic idx_valid(input logic [ADDR_W-1:0] idx);
        return ({1'b0, idx} < REG_COUNT) && !(ZERO_REG && (idx == '0));
    endfunction

    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [ADDR_W-1:0] idx);
        return ONE_HOT0 << idx;
    endfunction

    logic                wr_ok;
    logic                iss_ok;
    logic [NUM_REGS-1:0] wr_hot;
    logic [NUM_REGS-1:0] iss_hot;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;

    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                ra_ok;
    logic                ra_fwd;
    logic [DATA_W-1:0]   ra_data;
    logic                ra_busy;

    logic                rb_ok;
    logic                rb_fwd;
    logic [DATA_W-1:0]   rb_data;
    logic                rb_busy;

    // Illegal writes and issues (out of range or to the zero register)
    // decode to an all-zero one-hot, so they touch neither data nor busy bits.
    assign wr_ok   = bus.we && idx_valid(bus.waddr);
    assign iss_ok  = bus.iss_valid && idx_valid(bus.iss_rd);
    assign wr_hot  = wr_ok  ? idx_onehot(bus.waddr)  : '0;
    assign iss_hot = iss_ok ? idx_onehot(bus.iss_rd) : '0;

    // Storage: one enable register per index; the zero register has no flop.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (ZERO_REG && (g == 0)) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_flop
            regn_p #(
                .W (DATA_W)
            ) u_reg (
                .clk    (clk),
                .resetn (resetn),
                .en     (wr_hot[g]),
                .d      (bus.wdata),
                .q      (regs[g])
            );
        end
    end

    // Scoreboard next state. Flush or writeback clear first; a same-cycle
    // issue is applied last so the younger producer (or the instruction
    // issuing alongside a flush) keeps its destination busy.
    always_comb begin
        busy_next = busy_q;
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            busy_next = busy_q & ~wr_hot;
        end
        busy_next = busy_next | iss_hot;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign bus.busy_vec = busy_q;

    // Read port A. A forwarded write also reports not-busy because the
    // value the consumer is waiting for is on the port this cycle.
    always_comb begin
        ra_ok   = idx_valid(bus.ra_addr);
        ra_fwd  = BYPASS && wr_ok && (bus.waddr == bus.ra_addr);
        ra_data = '0;
        ra_busy = 1'b0;
        if (ra_ok) begin
            if (ra_fwd) begin
                ra_data = bus.wdata;
            end else begin
                ra_data = regs[bus.ra_addr];
                ra_busy = |(busy_q & idx_onehot(bus.ra_addr));
            end
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rb_ok   = idx_valid(bus.rb_addr);
        rb_fwd  = BYPASS && wr_ok && (bus.waddr == bus.rb_addr);
        rb_data = '0;
        rb_busy = 1'b0;
        if (rb_ok) begin
            if (rb_fwd) begin
                rb_data = bus.wdata;
            end else begin
                rb_data = regs[bus.rb_addr];
                rb_busy = |(busy_q & idx_onehot(bus.rb_addr));
            end
        end
    end

    assign bus.ra_data = ra_data;
    assign bus.ra_busy = ra_busy;
    assign bus.rb_data = rb_data;
    assign bus.rb_busy = rb_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//   Two register files side by side on the same stimulus:
//     dut0 : 32 registers, ZERO_REG=1, BYPASS=1
//     dut1 : 20 registers, ZERO_REG=0, BYPASS=0
//   A behavioural model (arrays of register values and busy flags) predicts
//   every output; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int NR0 = 32;
    localparam int NR1 = 20;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  ra_addr = '0;
    logic [4:0]  rb_addr = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        flush = 1'b0;
    logic        cmp_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(32), .NUM_REGS(NR0)) bus0 ();
    regfile_sb_if #(.DATA_W(32), .NUM_REGS(NR1)) bus1 ();

    assign bus0.we = we;          assign bus1.we = we;
    assign bus0.waddr = waddr;    assign bus1.waddr = waddr;
    assign bus0.wdata = wdata;    assign bus1.wdata = wdata;
    assign bus0.ra_addr = ra_addr; assign bus1.ra_addr = ra_addr;
    assign bus0.rb_addr = rb_addr; assign bus1.rb_addr = rb_addr;
    assign bus0.iss_valid = iss_valid; assign bus1.iss_valid = iss_valid;
    assign bus0.iss_rd = iss_rd;  assign bus1.iss_rd = iss_rd;
    assign bus0.flush = flush;    assign bus1.flush = flush;

    regfile_sb #(
        .DATA_W (32), .NUM_REGS (NR0), .ZERO_REG (1'b1), .BYPASS (1'b1)
    ) u_dut0 (
        .clk (clk), .resetn (resetn), .bus (bus0)
    );

    regfile_sb #(
        .DATA_W (32), .NUM_REGS (NR1), .ZERO_REG (1'b0), .BYPASS (1'b0)
    ) u_dut1 (
        .clk (clk), .resetn (resetn), .bus (bus1)
    );

    // ---------------- behavioural model ----------------
    int       nr_t [2] = '{NR0, NR1};
    bit       zr_t [2] = '{1'b1, 1'b0};
    bit       bp_t [2] = '{1'b1, 1'b0};
    bit [31:0] m_reg  [2][256];
    bit        m_busy [2][256];

    function automatic bit legal(int k, int idx);
        return (idx < nr_t[k]) && !(zr_t[k] && idx == 0);
    endfunction

    function automatic bit fwd(int k, int a);
        return bp_t[k] && we && legal(k, int'(waddr)) && (int'(waddr) == a);
    endfunction

    function automatic logic [63:0] exp_data(int k, int a);
        if (!legal(k, a)) return 64'd0;
        if (fwd(k, a))    return {32'd0, wdata};
        return {32'd0, m_reg[k][a]};
    endfunction

    function automatic logic [63:0] exp_busy(int k, int a);
        if (!legal(k, a) || fwd(k, a)) return 64'd0;
        return {63'd0, m_busy[k][a]};
    endfunction

    function automatic logic [63:0] exp_vec(int k);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nr_t[k]; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    always @(negedge resetn) begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) begin
                m_reg[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
    end

    always @(posedge clk) begin
        if (resetn) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < nr_t[k]; i++) begin
                    if (flush)
                        m_busy[k][i] = 1'b0;
                    else if (we && legal(k, int'(waddr)) && int'(waddr) == i)
                        m_busy[k][i] = 1'b0;
                    if (iss_valid && legal(k, int'(iss_rd)) && int'(iss_rd) == i)
                        m_busy[k][i] = 1'b1;
                end
                if (we && legal(k, int'(waddr)))
                    m_reg[k][int'(waddr)] = wdata;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- per-cycle comparison against the model ----------------
    always begin
        @(negedge clk);
        #2;
        if (cmp_en) begin
            check($sformatf("d0 ra_data[%0d]", ra_addr), {32'd0, bus0.ra_data}, exp_data(0, int'(ra_addr)));
            check($sformatf("d0 ra_busy[%0d]", ra_addr), {63'd0, bus0.ra_busy}, exp_busy(0, int'(ra_addr)));
            check($sformatf("d0 rb_data[%0d]", rb_addr), {32'd0, bus0.rb_data}, exp_data(0, int'(rb_addr)));
            check($sformatf("d0 rb_busy[%0d]", rb_addr), {63'd0, bus0.rb_busy}, exp_busy(0, int'(rb_addr)));
            check("d0 busy_vec", {32'd0, bus0.busy_vec}, exp_vec(0));
            check($sformatf("d1 ra_data[%0d]", ra_addr), {32'd0, bus1.ra_data}, exp_data(1, int'(ra_addr)));
            check($sformatf("d1 ra_busy[%0d]", ra_addr), {63'd0, bus1.ra_busy}, exp_busy(1, int'(ra_addr)));
            check($sformatf("d1 rb_data[%0d]", rb_addr), {32'd0, bus1.rb_data}, exp_data(1, int'(rb_addr)));
            check($sformatf("d1 rb_busy[%0d]", rb_addr), {63'd0, bus1.rb_busy}, exp_busy(1, int'(rb_addr)));
            check("d1 busy_vec", {44'd0, bus1.busy_vec}, exp_vec(1));
        end
    end

    task automatic idle();
        we = 1'b0; iss_valid = 1'b0; flush = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("reset d0 busy_vec", {32'd0, bus0.busy_vec}, 64'd0);
        check("reset d1 busy_vec", {44'd0, bus1.busy_vec}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // All indices read zero after reset on both ports.
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            ra_addr = 5'(a);
            rb_addr = 5'(31 - a);
            #3;
            check("scan d0 ra_data", {32'd0, bus0.ra_data}, 64'd0);
            check("scan d1 rb_data", {32'd0, bus1.rb_data}, 64'd0);
        end

        // Same-cycle write/read of index 5.
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; ra_addr = 5'd5;
        #3;
        check("bypass d0 ra_data", {32'd0, bus0.ra_data}, 64'hDEADBEEF);
        check("nobypass d1 ra_data", {32'd0, bus1.ra_data}, 64'd0);
        @(negedge clk);
        idle();
        #3;
        check("after d1 ra_data", {32'd0, bus1.ra_data}, 64'hDEADBEEF);
        check("after d0 ra_data", {32'd0, bus0.ra_data}, 64'hDEADBEEF);

        // Write + issue to index 0.
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; ra_addr = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #3;
        check("zero d0 ra_data same", {32'd0, bus0.ra_data}, 64'd0);
        @(negedge clk);
        idle();
        #3;
        check("zero d0 ra_data next", {32'd0, bus0.ra_data}, 64'd0);
        check("zero d0 busy_vec", {32'd0, bus0.busy_vec}, 64'd0);
        check("r0 d1 ra_data", {32'd0, bus1.ra_data}, 64'hFFFF_FFFF);
        check("r0 d1 busy_vec", {44'd0, bus1.busy_vec}, 64'h1);

        // Issue 7, then write back 7.
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd7; rb_addr = 5'd7;
        @(negedge clk);
        idle();
        #3;
        check("iss7 d0 rb_busy", {63'd0, bus0.rb_busy}, 64'd1);
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h42;
        #3;
        check("wb7 d0 rb_busy", {63'd0, bus0.rb_busy}, 64'd0);
        check("wb7 d0 rb_data", {32'd0, bus0.rb_data}, 64'h42);
        check("wb7 d1 rb_busy", {63'd0, bus1.rb_busy}, 64'd1);
        @(negedge clk);
        idle();
        #3;
        check("wb7 d0 busy_vec", {32'd0, bus0.busy_vec}, 64'd0);
        check("wb7 d1 rb_data", {32'd0, bus1.rb_data}, 64'h42);

        // Build busy 8..11, then write+issue 9 together with a flush.
        for (int j = 8; j < 12; j++) begin
            @(negedge clk);
            iss_valid = 1'b1; iss_rd = 5'(j);
        end
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h1234_5678;
        iss_valid = 1'b1; iss_rd = 5'd9; flush = 1'b1; ra_addr = 5'd9;
        #3;
        check("pre d0 busy_vec", {32'd0, bus0.busy_vec}, 64'h0F00);
        check("pre d1 busy_vec", {44'd0, bus1.busy_vec}, 64'h0F01);
        @(negedge clk);
        idle();
        #3;
        check("post d0 busy_vec", {32'd0, bus0.busy_vec}, 64'h0200);
        check("post d1 busy_vec", {44'd0, bus1.busy_vec}, 64'h0200);
        check("post d0 reg9", {32'd0, bus0.ra_data}, 64'h1234_5678);
        check("post d1 reg9", {32'd0, bus1.ra_data}, 64'h1234_5678);

        // Out-of-range index 25 on the 20-register file.
        @(negedge clk);
        we = 1'b1; waddr = 5'd25; wdata = 32'h0BAD;
        iss_valid = 1'b1; iss_rd = 5'd25; ra_addr = 5'd25;
        #3;
        check("oor d1 ra_data", {32'd0, bus1.ra_data}, 64'd0);
        check("oor d1 ra_busy", {63'd0, bus1.ra_busy}, 64'd0);
        check("r25 d0 ra_data", {32'd0, bus0.ra_data}, 64'h0BAD);
        @(negedge clk);
        idle();
        #3;
        check("oor d1 busy_vec", {44'd0, bus1.busy_vec}, 64'h0200);
        check("r25 d0 busy_vec", {32'd0, bus0.busy_vec}, 64'h0200_0200);
        check("r25 d0 ra_busy", {63'd0, bus0.ra_busy}, 64'd1);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("arst d0 busy_vec", {32'd0, bus0.busy_vec}, 64'd0);
        check("arst d1 busy_vec", {44'd0, bus1.busy_vec}, 64'd0);
        check("arst d0 ra_data", {32'd0, bus0.ra_data}, 64'd0);
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'h77; ra_addr = 5'd4; rb_addr = 5'd9;
        #3;
        check("arst d1 rb_data", {32'd0, bus1.rb_data}, 64'd0);
        @(negedge clk);
        idle();
        resetn = 1'b1;
        ra_addr = 5'd3;
        #3;
        check("arst d0 reg3", {32'd0, bus0.ra_data}, 64'd0);
        check("arst d1 reg3", {32'd0, bus1.ra_data}, 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            we        = ($urandom_range(0, 1) == 1);
            waddr     = 5'($urandom_range(0, 31));
            wdata     = $urandom;
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_rd    = 5'($urandom_range(0, 31));
            flush     = ($urandom_range(0, 15) == 0);
            ra_addr   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            rb_addr   = ($urandom_range(0, 3) == 0) ? iss_rd : 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        #4;
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
